// File: rtl/fetch_issue_if.sv
// Fetch/issue bus: instruction-memory read port, controller start/waiting handshake,
// decoded instruction fields and status. ADDR_W must match the attached fetch_issue_unit.
`timescale 1ns/1ps
interface fetch_issue_if #(
   parameter int ADDR_W = 8
);
   // Memory: the unit holds mem_rd and mem_addr until it samples mem_valid=1 on a rising
   // edge; that word is taken in that cycle. Controller: start stays high until waiting
   // is sampled low, and waiting returning high marks the instruction as done.
   logic              run;
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_rdata;
   logic              mem_valid;
   logic              waiting;
   logic              start;
   logic [2:0]        opcode;
   logic [1:0]        ALU_op;
   logic [1:0]        shift_op;
   logic [2:0]        Rn;
   logic [2:0]        Rd;
   logic [2:0]        Rm;
   logic [15:0]       sximm8;
   logic [15:0]       sximm5;
   logic [ADDR_W-1:0] pc;
   logic              halted;
   logic [2:0]        fsm_state;

   modport master (
      input  run, mem_rdata, mem_valid, waiting,
      output mem_rd, mem_addr, start, opcode, ALU_op, shift_op, Rn, Rd, Rm,
             sximm8, sximm5, pc, halted, fsm_state
   );

   modport slave (
      output run, mem_rdata, mem_valid, waiting,
      input  mem_rd, mem_addr, start, opcode, ALU_op, shift_op, Rn, Rd, Rm,
             sximm8, sximm5, pc, halted, fsm_state
   );
endinterface

// File: rtl/fetch_issue_unit.sv
// Fetches one instruction at a time into IR, issues it to the controller and advances the PC.
// Optional macro FETCH_HALT_EN: opcode 3'b111 parks the unit in HALTED until reset.
`timescale 1ns/1ps
module fetch_issue_unit #(
   parameter int                ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
   input logic         clk,
   input logic         rst,
   fetch_issue_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_REQ    = 3'd1,
      S_ISSUE  = 3'd2,
      S_EXEC   = 3'd3,
      S_HALTED = 3'd4
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [15:0]       ir;
   logic [ADDR_W-1:0] pc_q;
   logic              ir_load;
   logic              pc_inc;
   logic              mem_rd_c;
   logic              start_c;
   logic              halt_hit;

`ifdef FETCH_HALT_EN
   assign halt_hit = (bus.mem_rdata[15:13] == 3'b111);
`else
   assign halt_hit = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ir <= 16'h0000;
      end else if (ir_load) begin
         ir <= bus.mem_rdata;
      end
   end

   // PC moves only once the controller reports completion; an abandoned instruction never bumps it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= PC_RESET;
      end else if (pc_inc) begin
         pc_q <= pc_q + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      ir_load   = 1'b0;
      pc_inc    = 1'b0;
      mem_rd_c  = 1'b0;
      start_c   = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.run) state_nxt = S_REQ;
         end
         S_REQ: begin
            mem_rd_c = 1'b1;
            if (bus.mem_valid) begin
               ir_load   = 1'b1;
               state_nxt = halt_hit ? S_HALTED : S_ISSUE;
            end
         end
         S_ISSUE: begin
            start_c = 1'b1;
            if (!bus.waiting) state_nxt = S_EXEC;
         end
         S_EXEC: begin
            // run is looked at only here, when the instruction has fully retired.
            if (bus.waiting) begin
               pc_inc    = 1'b1;
               state_nxt = bus.run ? S_REQ : S_IDLE;
            end
         end
         S_HALTED: begin
            state_nxt = S_HALTED;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   assign bus.mem_rd    = mem_rd_c;
   assign bus.mem_addr  = pc_q;
   assign bus.start     = start_c;
   assign bus.pc        = pc_q;
   assign bus.fsm_state = state;

`ifdef FETCH_HALT_EN
   assign bus.halted = (state == S_HALTED);
`else
   assign bus.halted = 1'b0;
`endif

   assign bus.opcode   = ir[15:13];
   assign bus.ALU_op   = ir[12:11];
   assign bus.Rn       = ir[10:8];
   assign bus.Rd       = ir[7:5];
   assign bus.shift_op = ir[4:3];
   assign bus.Rm       = ir[2:0];
   assign bus.sximm8   = {{8{ir[7]}}, ir[7:0]};
   assign bus.sximm5   = {{11{ir[4]}}, ir[4:0]};

endmodule

// File: tb/tb_fetch_issue_unit.sv
// Directed bench for fetch_issue_unit: decode vector table plus reset, stall, wrap and halt sequences.
`timescale 1ns/1ps
module tb_fetch_issue_unit;

   typedef struct {
      logic [15:0] instr;
      int          stall;
      logic [2:0]  opcode;
      logic [1:0]  alu_op;
      logic [2:0]  rn;
      logic [2:0]  rd;
      logic [1:0]  shift_op;
      logic [2:0]  rm;
      logic [15:0] sximm5;
      logic [15:0] sximm8;
   } vec_t;

   logic        clk;
   logic        rst;
   int          total;
   int          bad;
   logic [15:0] exp_q[$];
   logic [7:0]  exp_pc;
   logic        start_prev;
   vec_t        vecs[6];

   fetch_issue_if #(.ADDR_W(8)) bus ();

   fetch_issue_unit #(.ADDR_W(8), .PC_RESET(8'h00)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, act=running exp=finished");
      $fatal(1, "watchdog");
   end

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: act=%0h exp=%0h at %0t", name, act, exp, $time);
      end
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic logic [15:0] rand_instr();
      logic [15:0] w;
      w = 16'($urandom);
      w[15:13] = 3'($urandom_range(0, 6));
      return w;
   endfunction

   // scoreboard: each rising start must carry the next expected instruction word
   always @(negedge clk) begin
      if (bus.start && !start_prev) begin
         if (exp_q.size() == 0) begin
            check("issue_unexpected", 32'(bus.opcode), 32'hFFFF_FFFF);
         end else begin
            check("issue_word",
                  {16'h0, bus.opcode, bus.ALU_op, bus.Rn, bus.Rd, bus.shift_op, bus.Rm},
                  {16'h0, exp_q.pop_front()});
         end
      end
      start_prev <= bus.start;
   end

   // driver: REQ at the current negedge -> ISSUE at return
   task automatic fetch(input logic [15:0] instr, input int stall, input logic [7:0] addr);
      for (int s = 0; s < stall; s++) begin
         check("stall_rd", bus.mem_rd, 1);
         check("stall_addr", bus.mem_addr, addr);
         check("stall_start", bus.start, 0);
         bus.mem_valid = 1'b0;
         bus.mem_rdata = 16'($urandom);
         tick();
      end
      check("req_rd", bus.mem_rd, 1);
      check("req_addr", bus.mem_addr, addr);
      check("req_start", bus.start, 0);
      bus.mem_valid = 1'b1;
      bus.mem_rdata = instr;
      exp_q.push_back(instr);
      tick();
      bus.mem_valid = 1'b0;
      bus.mem_rdata = 16'($urandom);
      check("issue_start", bus.start, 1);
      check("issue_rd", bus.mem_rd, 0);
   endtask

   // controller model: takes start, drops waiting, raises it again after lat cycles
   task automatic complete(input int lat, input logic run_next, input logic [7:0] pc_now);
      logic [7:0] pc_next;
      pc_next = pc_now + 8'd1;
      bus.run = run_next;
      tick();
      check("hold_start", bus.start, 1);
      bus.waiting = 1'b0;
      tick();
      for (int i = 0; i < lat; i++) begin
         check("exec_start", bus.start, 0);
         check("exec_rd", bus.mem_rd, 0);
         check("exec_pc", bus.pc, pc_now);
         if (i == lat - 1) bus.waiting = 1'b1;
         tick();
      end
      check("next_pc", bus.pc, pc_next);
      check("next_state", bus.fsm_state, run_next ? 32'd1 : 32'd0);
   endtask

   function automatic void check_fields(vec_t v);
      check("opcode", bus.opcode, v.opcode);
      check("alu_op", bus.ALU_op, v.alu_op);
      check("rn", bus.Rn, v.rn);
      check("rd", bus.Rd, v.rd);
      check("shift_op", bus.shift_op, v.shift_op);
      check("rm", bus.Rm, v.rm);
      check("sximm5", bus.sximm5, v.sximm5);
      check("sximm8", bus.sximm8, v.sximm8);
   endfunction

   initial begin
      total = 0;
      bad = 0;
      start_prev = 1'b0;
      rst = 1'b1;
      bus.run = 1'b0;
      bus.mem_valid = 1'b0;
      bus.mem_rdata = 16'h0000;
      bus.waiting = 1'b1;

      vecs[0] = '{16'hA0F3, 0, 3'b101, 2'b00, 3'd0, 3'd7, 2'b10, 3'd3, 16'hFFF3, 16'hFFF3};
      vecs[1] = '{16'hD305, 1, 3'b110, 2'b10, 3'd3, 3'd0, 2'b00, 3'd5, 16'h0005, 16'h0005};
      vecs[2] = '{16'h6F8F, 0, 3'b011, 2'b01, 3'd7, 3'd4, 2'b01, 3'd7, 16'h000F, 16'hFF8F};
      vecs[3] = '{16'hB96A, 2, 3'b101, 2'b11, 3'd1, 3'd3, 2'b01, 3'd2, 16'h000A, 16'h006A};
      vecs[4] = '{16'h8470, 0, 3'b100, 2'b00, 3'd4, 3'd3, 2'b10, 3'd0, 16'hFFF0, 16'h0070};
      vecs[5] = '{16'hC2FF, 0, 3'b110, 2'b00, 3'd2, 3'd7, 2'b11, 3'd7, 16'hFFFF, 16'hFFFF};

      // reset state
      tick();
      check("rst_start", bus.start, 0);
      check("rst_rd", bus.mem_rd, 0);
      check("rst_pc", bus.pc, 0);
      check("rst_state", bus.fsm_state, 0);
      check("rst_halted", bus.halted, 0);
      check("rst_opcode", bus.opcode, 0);
      check("rst_sximm8", bus.sximm8, 0);
      rst = 1'b0;
      tick();
      tick();
      check("idle_rd", bus.mem_rd, 0);
      check("idle_state", bus.fsm_state, 0);

      // single instruction, zero-wait memory
      exp_pc = 8'h00;
      bus.run = 1'b1;
      tick();
      fetch(16'hD305, 0, exp_pc);
      check("mov_opcode", bus.opcode, 3'b110);
      check("mov_alu", bus.ALU_op, 2'b10);
      check("mov_rn", bus.Rn, 3'd3);
      check("mov_imm8", bus.sximm8, 16'h0005);
      complete(3, 1'b1, exp_pc);
      exp_pc++;

      // decode table
      for (int i = 0; i < 6; i++) begin
         fetch(vecs[i].instr, vecs[i].stall, exp_pc);
         check_fields(vecs[i]);
         complete(2, 1'b1, exp_pc);
         exp_pc++;
      end

      // four-cycle memory stall; IR must hold the previous word meanwhile
      check("pre_stall_opcode", bus.opcode, 3'b110);
      fetch(16'h4123, 4, exp_pc);
      check("stall_opcode", bus.opcode, 3'b010);
      complete(1, 1'b0, exp_pc);
      exp_pc++;
      tick();
      check("stall_idle_rd", bus.mem_rd, 0);

      // run up to 8'hFF, drop run during the last instruction and wrap
      bus.run = 1'b1;
      tick();
      while (exp_pc != 8'hFF) begin
         fetch(rand_instr(), 0, exp_pc);
         complete(1, 1'b1, exp_pc);
         exp_pc++;
      end
      fetch(16'h1234, 0, 8'hFF);
      complete(2, 1'b0, 8'hFF);
      exp_pc = 8'h00;
      tick();
      tick();
      check("wrap_rd", bus.mem_rd, 0);
      check("wrap_state", bus.fsm_state, 0);
      check("wrap_pc", bus.pc, 8'h00);

      // reset while executing at pc 5
      bus.run = 1'b1;
      tick();
      while (exp_pc != 8'h05) begin
         fetch(rand_instr(), 0, exp_pc);
         complete(1, 1'b1, exp_pc);
         exp_pc++;
      end
      fetch(16'hD305, 0, 8'h05);
      tick();
      bus.waiting = 1'b0;
      tick();
      check("mid_state", bus.fsm_state, 3);
      check("mid_pc", bus.pc, 8'h05);
      rst = 1'b1;
      #1;
      check("arst_start", bus.start, 0);
      check("arst_rd", bus.mem_rd, 0);
      check("arst_opcode", bus.opcode, 0);
      check("arst_pc", bus.pc, 8'h00);
      bus.waiting = 1'b1;
      bus.run = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      tick();
      check("post_rst_rd", bus.mem_rd, 0);
      check("post_rst_pc", bus.pc, 8'h00);
      check("post_rst_state", bus.fsm_state, 0);
      exp_pc = 8'h00;

      // halt opcode at pc 2
      bus.run = 1'b1;
      tick();
      while (exp_pc != 8'h02) begin
         fetch(rand_instr(), 0, exp_pc);
         complete(1, 1'b1, exp_pc);
         exp_pc++;
      end
`ifdef FETCH_HALT_EN
      check("halt_req_rd", bus.mem_rd, 1);
      bus.mem_valid = 1'b1;
      bus.mem_rdata = 16'hE000;
      tick();
      bus.mem_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("halted", bus.halted, 1);
         check("halt_start", bus.start, 0);
         check("halt_rd", bus.mem_rd, 0);
         check("halt_pc", bus.pc, 8'h02);
         bus.waiting = 1'(i);
         tick();
      end
      bus.waiting = 1'b1;
      rst = 1'b1;
      #1;
      check("halt_rst_halted", bus.halted, 0);
      check("halt_rst_state", bus.fsm_state, 0);
      tick();
      rst = 1'b0;
`else
      fetch(16'hE000, 0, 8'h02);
      check("op7_opcode", bus.opcode, 3'b111);
      check("op7_halted", bus.halted, 0);
      complete(1, 1'b0, 8'h02);
`endif
      tick();
      check("queue_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
